// File: rtl/control_unit_mc_if.sv
// Bundle between the multicycle controller and its datapath: instruction fields
// and compare result in, datapath strobes/selects and debug status out.
interface control_unit_mc_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       comp;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    modport master (
        output opcode, funct3, comp,
        input  pc_write, ir_write, mem_write, reg_write, adr_src,
        input  alu_src_a, alu_src_b, result_src, alu_control, state, illegal
    );

    modport slave (
        input  opcode, funct3, comp,
        output pc_write, ir_write, mem_write, reg_write, adr_src,
        output alu_src_a, alu_src_b, result_src, alu_control, state, illegal
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multicycle RISC-V style Moore controller with a sticky illegal-opcode flag.
// Define CTRL_ILLEGAL_HALT_EN to park in HALT on an illegal opcode instead of treating it as a NOP.
module control_unit_mc (
    input  logic              clk,
    input  logic              rst,
    control_unit_mc_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_illegal_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic [2:0] w_alu_control;

    function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b001:  alu_from_funct3 = 3'b001;
            3'b111:  alu_from_funct3 = 3'b010;
            default: alu_from_funct3 = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_illegal_op)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_illegal_op  = 1'b0;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b0110111:             w_next = S_LUI;
                    default: begin
                        w_illegal_op = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
                        w_next = S_HALT;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu_control = alu_from_funct3(bus.funct3);
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            // Branch resolution is the one output allowed to follow comp within the cycle.
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = (bus.funct3 == 3'b101) ? 3'b100 : 3'b011;
                case (bus.funct3)
                    3'b000:  w_pc_write = ~bus.comp;
                    3'b001:  w_pc_write = bus.comp;
                    3'b101:  w_pc_write = bus.comp;
                    default: w_pc_write = 1'b0;
                endcase
                w_next = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_LUI: begin
                w_alu_src_b   = 2'b01;
                w_alu_control = 3'b101;
                w_next        = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ir_write    = w_ir_write;
    assign bus.mem_write   = w_mem_write;
    assign bus.reg_write   = w_reg_write;
    assign bus.adr_src     = w_adr_src;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.result_src  = w_result_src;
    assign bus.alu_control = w_alu_control;
    assign bus.state       = r_state;
    assign bus.illegal     = r_illegal;
endmodule
